// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store encodings, FSM state type and lane helpers for mem_access_unit.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } mau_state_e;

  function automatic logic f3_illegal(input logic [2:0] f3);
    logic r;
    case (f3)
      3'b011, 3'b110, 3'b111: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a 32-bit bus read word.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // pick the addressed byte/halfword lane
  always_comb begin
    byte_s = 8'h00;
    case (offset_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // extend according to load type
  always_comb begin
    data_o = 32'h0000_0000;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {24'h00_0000, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LHU:  data_o = {16'h0000, half_s};
      F3_LW:   data_o = rdata_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: stalls the pipeline while one bus access is outstanding.
// Optional feature macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW are trapped instead of issued.
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  functM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic        stall_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  mau_state_e  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        stall_s;
  logic        misal_s;
  logic        skip_s;
  logic [31:0] aligned_s;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

`ifdef MISALIGN_TRAP_EN
  assign misal_s = is_misaligned(functM, addrM[1:0]);
`else
  assign misal_s = 1'b0;
`endif
  assign skip_s = f3_illegal(functM) | misal_s;

  load_align u_load_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .rdata_i  (bus_rdata),
    .data_o   (aligned_s)
  );

  // next-state and datapath update
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    we_d         = we_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    stall_s      = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_writeM || mem_readM) begin
          stall_s  = 1'b1;
          funct3_d = functM;
          off_d    = addrM[1:0];
          we_d     = mem_writeM;
          if (skip_s) begin
            // trapped/illegal accesses never reach the bus
            state_d      = DONE;
            load_data_d  = 32'h0000_0000;
            load_valid_d = ~mem_writeM;
`ifdef MISALIGN_TRAP_EN
            misalign_d   = misal_s;
`endif
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_writeM;
            bus_addr_d  = {addrM[31:2], 2'b00};
            bus_be_d    = byte_enables(functM, addrM[1:0]);
            bus_wdata_d = mem_writeM ? store_lanes(functM, wdataM) : 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          if (we_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT_R: begin
        stall_s = 1'b1;
        if (bus_rvalid) begin
          state_d      = DONE;
          load_data_d  = aligned_s;
          load_valid_d = 1'b1;
        end else begin
          state_d = WAIT_R;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      we_q         <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_wdata_q  <= 32'h0000_0000;
      bus_be_q     <= 4'b0000;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      we_q         <= we_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // stall must be visible in the request cycle itself, so it stays combinational
  assign stall_mem  = stall_s & ~rst;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: mem_readM  in  1, mem_writeM  in  1  MEM-stage access request from pipeline register.
REQ-004 SHALL have ports: functM  in  3  RV32I funct3; addrM  in  32  ALU effective address; wdataM  in  32  store source (rs2).
REQ-005 SHALL have ports: stall_mem  out  1  hold IF..EX/MEM while access outstanding.
REQ-006 SHALL have ports: load_data  out  32  aligned, extended load result; load_valid  out  1  load_data valid this cycle.
REQ-007 SHALL have ports: bus_req  out  1, bus_we  out  1, bus_addr  out  32 (bits[1:0]=0), bus_wdata  out  32, bus_be  out  4.
REQ-008 SHALL have ports: bus_gnt  in  1  request accepted; bus_rvalid  in  1, bus_rdata  in  32  read return.
REQ-009 SHALL have port (MISALIGN_TRAP_EN only): misalign_err  out  1  misaligned access flag.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT_R, DONE.
REQ-011 SHALL, in IDLE with mem_writeM or mem_readM, assert stall_mem combinationally in that cycle and enter REQ; mem_writeM has priority if both high.
REQ-012 SHALL latch addr, funct3, store data and direction on IDLE->REQ; pipeline inputs ignored until IDLE again.
REQ-013 SHALL hold bus_req and all bus outputs stable in REQ until bus_gnt=1.
REQ-014 SHALL, on bus_gnt in REQ: store -> DONE; load -> WAIT_R. bus_rvalid is never sampled in the grant cycle.
REQ-015 SHALL, on bus_rvalid in WAIT_R, capture the extended result and enter DONE.
REQ-016 SHALL, in DONE, deassert stall_mem, drive load_valid=1 for loads (0 for stores) and return to IDLE next cycle; minimum access latency = 3 cycles store, 4 cycles load with zero-wait bus.
REQ-017 SHALL keep stall_mem=1 in REQ and WAIT_R, 0 in DONE and in IDLE without request.
REQ-018 SHALL generate bus_be: SB 4'b0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111; bus_wdata replicates byte (SB) or halfword (SH).
REQ-019 SHALL extract loads by addr lanes: LB sign-extend, LBU zero-extend, LH/LHU by addr[1] with sign/zero extension, LW full word.
REQ-020 SHALL treat funct3 011/110/111 as illegal: no bus request, go straight to DONE, load_data=0.
REQ-021 SHALL hold load_data at last captured value outside DONE.

Reset
REQ-022 SHALL, on rst, force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data=0, load_valid=0, misalign_err=0, stall_mem=0 (registered terms).
REQ-023 SHALL abandon any in-flight access on rst; bus_rvalid arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-024 SHALL with MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 issue no bus request, go to DONE, pulse misalign_err for that DONE cycle, load_data=0.
REQ-025 SHALL without MISALIGN_TRAP_EN: no misalign_err port; misaligned halfword uses addr[1] lanes, misaligned word ignores addr[1:0].

Structure
REQ-026 SHALL place funct3 encodings (LB..LHU, SB..SW) and FSM state encoding in shared package riscv_mem_pkg.
REQ-027 SHALL contain one sub-module load_align (combinational lane select and extension).

Verification
REQ-028 SW addr 0x100 data 0xDEADBEEF, gnt after 2 waits -> bus_be=1111, bus_addr=0x100, stall 4 cycles, load_valid=0 in DONE.
REQ-029 LB addr 0x203, rdata 0x80FF0011 -> bus_be=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SH addr 0x302 data 0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD.
REQ-031 LW addr 0x101 with MISALIGN_TRAP_EN -> no bus_req, misalign_err=1 one cycle, load_data=0; without -> bus_addr=0x100, bus_be=1111.
REQ-032 rst asserted in WAIT_R, rvalid one cycle later -> IDLE, stall_mem=0, load_valid stays 0.
REQ-033 mem_readM and mem_writeM both 1, funct3=010 -> store issued (bus_we=1).
